// File: rtl/hazard_scoreboard_ctrl.sv
// hazard_scoreboard_ctrl
// Decode-stage sequencer for the 16-bit pipeline. A per-register pending-write
// counter detects RAW hazards and stalls decode. A taken branch starts a fixed
// flush sequence and removes the scoreboard entries of the killed instructions.
// Optional feature macro: HAZARD_WB_BYPASS_EN. When it is defined, a source whose
// only outstanding write is retiring this cycle is forwarded by the regfile and
// does not stall.
module hazard_scoreboard_ctrl #(
  parameter int NREGS        = 16,
  parameter int RW           = 4,
  parameter int CNT_W        = 2,
  parameter int KILL_DEPTH   = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dec_valid,
  input  logic [RW-1:0] dec_rs1,
  input  logic [RW-1:0] dec_rs2,
  input  logic          dec_use1,
  input  logic          dec_use2,
  input  logic [RW-1:0] dec_rd,
  input  logic          dec_wr,
  input  logic          wb_valid,
  input  logic [RW-1:0] wb_rd,
  input  logic          br_flush,
  output logic          stall,
  output logic          bubble,
  output logic          issue,
  output logic          flushing
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                      state;
  logic [FC_W-1:0]             fcnt;
  logic [CNT_W-1:0]            cnt     [NREGS];
  logic [CNT_W-1:0]            cnt_nxt [NREGS];
  logic [KILL_DEPTH-1:0]       hist_v;
  logic [KILL_DEPTH-1:0][RW-1:0] hist_rd;

  logic byp1, byp2;
  logic busy1, busy2;
  logic hazard, sat;

  // Number of history entries that target register r.
  function automatic int kill_hits(input logic [RW-1:0] r,
                                   input logic [KILL_DEPTH-1:0] hv,
                                   input logic [KILL_DEPTH-1:0][RW-1:0] hrd);
    int n;
    n = 0;
    for (int k = 0; k < KILL_DEPTH; k++) begin
      if (hv[k] && (hrd[k] == r)) n++;
    end
    return n;
  endfunction

  // Apply one increment and ndec decrements, clamping to [0, CNT_MAX].
  function automatic logic [CNT_W-1:0] sat_update(input logic [CNT_W-1:0] c,
                                                  input logic inc,
                                                  input int ndec);
    int n;
    n = int'(c) + (inc ? 1 : 0) - ndec;
    if (n < 0) n = 0;
    if (n > int'(CNT_MAX)) n = int'(CNT_MAX);
    return CNT_W'(n);
  endfunction

`ifdef HAZARD_WB_BYPASS_EN
  assign byp1 = wb_valid && (wb_rd == dec_rs1) && (cnt[dec_rs1] == CNT_W'(1));
  assign byp2 = wb_valid && (wb_rd == dec_rs2) && (cnt[dec_rs2] == CNT_W'(1));
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign busy1  = dec_use1 && (dec_rs1 != '0) && (cnt[dec_rs1] != '0) && !byp1;
  assign busy2  = dec_use2 && (dec_rs2 != '0) && (cnt[dec_rs2] != '0) && !byp2;
  assign hazard = dec_valid && (busy1 || busy2);
  assign sat    = dec_valid && dec_wr && (dec_rd != '0) && (cnt[dec_rd] == CNT_MAX) &&
                  !(wb_valid && (wb_rd == dec_rd));

  // Pipeline-register controls; flush overrides everything, reset forces all low.
  always_comb begin
    issue  = 1'b0;
    stall  = 1'b0;
    bubble = 1'b0;
    if (!rst) begin
      if ((state == FLUSH) || br_flush) begin
        bubble = 1'b1;
      end else begin
        issue  = dec_valid && !hazard && !sat;
        stall  = hazard || sat;
        bubble = !issue;
      end
    end
  end

  // Next pending count per register: issue, retire and flush kills combined.
  always_comb begin
    cnt_nxt[0] = '0;
    for (int r = 1; r < NREGS; r++) begin
      cnt_nxt[r] = sat_update(cnt[r],
                              issue && dec_wr && (dec_rd == RW'(r)),
                              ((wb_valid && (wb_rd == RW'(r))) ? 1 : 0) +
                              (br_flush ? kill_hits(RW'(r), hist_v, hist_rd) : 0));
    end
  end

  // Scoreboard counters.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREGS; r++) begin
      if (rst) cnt[r] <= '0;
      else     cnt[r] <= cnt_nxt[r];
    end
  end

  // Issue history valid bits; cleared by reset and by a flush.
  always_ff @(posedge clk) begin
    if (rst || br_flush) begin
      hist_v <= '0;
    end else begin
      hist_v[0] <= issue && dec_wr;
      for (int k = 1; k < KILL_DEPTH; k++) hist_v[k] <= hist_v[k-1];
    end
  end

  // Issue history destination indices, shifted every cycle.
  always_ff @(posedge clk) begin
    hist_rd[0] <= dec_rd;
    for (int k = 1; k < KILL_DEPTH; k++) hist_rd[k] <= hist_rd[k-1];
  end

  // RUN/FLUSH sequencer; a branch during FLUSH restarts the bubble count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      fcnt     <= '0;
      flushing <= 1'b0;
    end else if (br_flush) begin
      state    <= FLUSH;
      fcnt     <= FC_W'(FLUSH_CYCLES - 1);
      flushing <= 1'b1;
    end else begin
      case (state)
        RUN: begin
          flushing <= 1'b0;
        end
        FLUSH: begin
          if (fcnt == '0) begin
            state    <= RUN;
            flushing <= 1'b0;
          end else begin
            fcnt     <= fcnt - FC_W'(1);
            flushing <= 1'b1;
          end
        end
        default: begin
          state    <= RUN;
          flushing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Testbench for hazard_scoreboard_ctrl: directed scenarios followed by random
// traffic, compared against a cycle-level reference model of the scoreboard.
module tb_hazard_scoreboard_ctrl;

  localparam int NREGS        = 16;
  localparam int RW           = 4;
  localparam int KILL_DEPTH   = 2;
  localparam int FLUSH_CYCLES = 2;
  localparam int MAXC         = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          dec_valid;
  logic [RW-1:0] dec_rs1, dec_rs2, dec_rd, wb_rd;
  logic          dec_use1, dec_use2, dec_wr, wb_valid, br_flush;
  logic          stall, bubble, issue, flushing;

  always #5 clk = ~clk;

  hazard_scoreboard_ctrl #(
    .NREGS(NREGS), .RW(RW), .CNT_W(2), .KILL_DEPTH(KILL_DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use1(dec_use1), .dec_use2(dec_use2), .dec_rd(dec_rd), .dec_wr(dec_wr),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .br_flush(br_flush),
    .stall(stall), .bubble(bubble), .issue(issue), .flushing(flushing)
  );

  typedef struct {
    int cyc;
    bit stall;
    bit bubble;
    bit issue;
    bit flushing;
  } exp_t;

  typedef struct {
    int cyc;
    int rd;
  } wr_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  int  m_cnt[NREGS];
  int  m_flush_left = 0;
  wr_t m_hist[$];
  int  m_cyc = 0;
  bit  m_last_issue = 0;

  function automatic bit src_busy(int u, int s, int wbv, int wbrd);
    bit b;
    b = (u != 0) && (s != 0) && (m_cnt[s] != 0);
`ifdef HAZARD_WB_BYPASS_EN
    if ((wbv != 0) && (wbrd == s) && (m_cnt[s] == 1)) b = 0;
`endif
    return b;
  endfunction

  // Drive one cycle of inputs, predict the outputs, advance the model.
  task automatic step(int r, int v, int s1, int s2, int u1, int u2,
                      int d, int w, int wbv, int wbrd, int bf);
    exp_t e;
    bit   haz, sat, inflush;
    @(posedge clk);
    #1;
    rst       = (r != 0);
    dec_valid = (v != 0);
    dec_rs1   = RW'(s1);
    dec_rs2   = RW'(s2);
    dec_use1  = (u1 != 0);
    dec_use2  = (u2 != 0);
    dec_rd    = RW'(d);
    dec_wr    = (w != 0);
    wb_valid  = (wbv != 0);
    wb_rd     = RW'(wbrd);
    br_flush  = (bf != 0);

    e.cyc      = m_cyc;
    e.flushing = (m_flush_left > 0);
    e.stall = 0; e.bubble = 0; e.issue = 0;
    inflush = (m_flush_left > 0);

    if (r != 0) begin
      for (int i = 0; i < NREGS; i++) m_cnt[i] = 0;
      m_hist.delete();
      m_flush_left = 0;
    end else begin
      haz = (v != 0) && (src_busy(u1, s1, wbv, wbrd) || src_busy(u2, s2, wbv, wbrd));
      sat = (v != 0) && (w != 0) && (d != 0) && (m_cnt[d] == MAXC) &&
            !((wbv != 0) && (wbrd == d));
      if ((bf != 0) || inflush) begin
        e.bubble = 1;
      end else begin
        e.issue  = (v != 0) && !haz && !sat;
        e.stall  = haz || sat;
        e.bubble = !e.issue;
      end
      if (e.issue && (w != 0) && (d != 0)) begin
        m_cnt[d]++;
        m_hist.push_back('{cyc: m_cyc, rd: d});
      end
      if ((wbv != 0) && (wbrd != 0) && (m_cnt[wbrd] > 0)) m_cnt[wbrd]--;
      if (bf != 0) begin
        foreach (m_hist[k]) begin
          if ((m_cyc - m_hist[k].cyc) <= KILL_DEPTH && m_cnt[m_hist[k].rd] > 0)
            m_cnt[m_hist[k].rd]--;
        end
        m_hist.delete();
        m_flush_left = FLUSH_CYCLES;
      end else if (m_flush_left > 0) begin
        m_flush_left--;
      end
      while (m_hist.size() > 0 && (m_cyc + 1 - m_hist[0].cyc) > KILL_DEPTH)
        void'(m_hist.pop_front());
    end
    m_last_issue = e.issue;
    m_cyc++;
    expq.push_back(e);
  endtask

  task automatic chk(string nm, int cyc, bit got, bit want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0b want=%0b", nm, cyc, got, want);
    end
  endtask

  // Monitor: compare the DUT's outputs mid-cycle against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("stall",    e.cyc, stall,    e.stall);
        chk("bubble",   e.cyc, bubble,   e.bubble);
        chk("issue",    e.cyc, issue,    e.issue);
        chk("flushing", e.cyc, flushing, e.flushing);
      end
    end
  end

  initial begin
    int s1, s2, u1, u2, d, w, v, wbv, wbrd, bf, r, st;
    rst = 1; dec_valid = 0; dec_rs1 = '0; dec_rs2 = '0; dec_use1 = 0; dec_use2 = 0;
    dec_rd = '0; dec_wr = 0; wb_valid = 0; wb_rd = '0; br_flush = 0;
    for (int i = 0; i < NREGS; i++) m_cnt[i] = 0;

    repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // RAW on r3, released by writeback
    step(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    repeat (2) step(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3, 0, 1, 0, 0, 0, 1, 3, 0);
    step(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
    // Saturation on r5
    repeat (3) step(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    repeat (2) step(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 5, 1, 1, 5, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0);
    // Flush kills r2, r4
    step(0, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
    step(0, 1, 2, 4, 1, 1, 0, 0, 0, 0, 1);
    repeat (3) step(0, 1, 2, 4, 1, 1, 0, 0, 0, 0, 0);
    // Flush combined with writeback of r2, cnt[2]=2
    step(0, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1);
    repeat (3) step(0, 1, 2, 0, 1, 0, 0, 0, 0, 0, 0);
    // r0 is never tracked
    repeat (2) step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    // Reset in the middle of a stall
    step(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);

    // Random traffic; decode holds its instruction while it is not issued
    s1 = 0; s2 = 0; u1 = 0; u2 = 0; d = 0; w = 0; v = 0;
    for (int i = 0; i < 2500; i++) begin
      if (m_last_issue || !v || $urandom_range(0, 4) == 0) begin
        v  = ($urandom_range(0, 5) != 0);
        s1 = $urandom_range(0, 5);
        s2 = $urandom_range(0, 5);
        u1 = $urandom_range(0, 1);
        u2 = $urandom_range(0, 1);
        d  = $urandom_range(0, 4);
        w  = ($urandom_range(0, 3) != 0);
      end
      wbv  = ($urandom_range(0, 2) == 0);
      wbrd = $urandom_range(0, 5);
      if ($urandom_range(0, 4) != 0) begin
        st = $urandom_range(1, NREGS - 1);
        for (int k = 0; k < NREGS - 1; k++) begin
          if (m_cnt[1 + (st - 1 + k) % (NREGS - 1)] != 0) begin
            wbrd = 1 + (st - 1 + k) % (NREGS - 1);
            break;
          end
        end
      end
      bf = ($urandom_range(0, 14) == 0);
      r  = ($urandom_range(0, 199) == 0);
      step(r, v, s1, s2, u1, u2, d, w, wbv, wbrd, bf);
    end

    repeat (3) @(posedge clk);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
